// File: rtl/gpio_shk_mc.sv
// GPIO-word to multi-channel valid/ready handshake bridge.
// Optional timeout watchdog: define GPIO_SHK_TIMEOUT_EN.
module gpio_shk_mc #(
  parameter int WD_GPIO = 64,
  parameter int WD_SYNC = 16,
  parameter int WD_DLAY = 15,
  parameter int WD_CSEL = 2,
  parameter int WD_TOUT = 16,
  localparam int NUM_CHAN = 2**WD_CSEL
) (
  input  logic                        s_sys_base_clock,
  input  logic                        s_sys_base_reset,
  input  logic [WD_GPIO-1:0]          s_gpio_shk_tri_o,
  output logic [WD_GPIO-1:0]          s_gpio_shk_tri_i,
  output logic [NUM_CHAN-1:0]         m_shk_ctrl_wvalid,
  output logic [WD_SYNC-1:0]          m_shk_ctrl_smosi,
  output logic [WD_DLAY-1:0]          m_shk_ctrl_dmosi,
  input  logic [NUM_CHAN-1:0]         m_shk_ctrl_wready,
  input  logic [NUM_CHAN*WD_SYNC-1:0] m_shk_ctrl_smiso,
  input  logic [NUM_CHAN*WD_DLAY-1:0] m_shk_ctrl_dmiso
);

  localparam int DB = WD_SYNC + 1;
  localparam int CB = WD_SYNC + WD_DLAY + 1;
  localparam int CW = CB + WD_CSEL;

  typedef enum logic {
    IDLE,
    VALID
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cmd_q;
  logic                 req_q, req_d;
  logic                 ack_q, ack_d;
  logic [WD_CSEL-1:0]   chan_q, chan_d;
  logic [WD_SYNC-1:0]   smosi_q, smosi_d;
  logic [WD_DLAY-1:0]   dmosi_q, dmosi_d;
  logic [WD_SYNC-1:0]   smiso_q, smiso_d;
  logic [WD_DLAY-1:0]   dmiso_q, dmiso_d;
  logic                 start;
  logic                 xfer;
  logic                 tout_hit;
  logic [WD_SYNC-1:0]   sel_smiso;
  logic [WD_DLAY-1:0]   sel_dmiso;
  logic                 unused_cmd;

  assign unused_cmd = ^s_gpio_shk_tri_o[WD_GPIO-1:CW];

  assign xfer = (state_q == VALID) & m_shk_ctrl_wready[chan_q];
  assign sel_smiso = m_shk_ctrl_smiso[chan_q*WD_SYNC +: WD_SYNC];
  assign sel_dmiso = m_shk_ctrl_dmiso[chan_q*WD_DLAY +: WD_DLAY];

`ifdef GPIO_SHK_TIMEOUT_EN
  logic [WD_TOUT-1:0] cnt_q, cnt_d;
  logic               tflag_q, tflag_d;

  // Fires on the VALID edge whose increment would reach all-ones.
  assign tout_hit = (state_q == VALID) & (&(cnt_q + 1'b1));

  always_comb begin
    cnt_d   = cnt_q;
    tflag_d = tflag_q;
    if (start) begin
      cnt_d   = '0;
      tflag_d = 1'b0;
    end else if (state_q == VALID) begin
      cnt_d = cnt_q + 1'b1;
      if (tout_hit && !xfer) begin
        tflag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge s_sys_base_clock) begin
    if (s_sys_base_reset) begin
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end
`else
  localparam int unused_wd_tout = WD_TOUT;
  assign tout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ack_d   = ack_q;
    chan_d  = chan_q;
    smosi_d = smosi_q;
    dmosi_d = dmosi_q;
    smiso_d = smiso_q;
    dmiso_d = dmiso_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_q[0] != req_q) begin
          state_d = VALID;
          req_d   = cmd_q[0];
          smosi_d = cmd_q[1 +: WD_SYNC];
          dmosi_d = cmd_q[DB +: WD_DLAY];
          chan_d  = cmd_q[CB +: WD_CSEL];
          start   = 1'b1;
        end
      end
      VALID: begin
        // A transfer on the timeout edge wins.
        if (xfer) begin
          state_d = IDLE;
          ack_d   = req_q;
          smiso_d = sel_smiso;
          dmiso_d = sel_dmiso;
        end else if (tout_hit) begin
          state_d = IDLE;
          ack_d   = req_q;
          smiso_d = '0;
          dmiso_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_sys_base_clock) begin
    if (s_sys_base_reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      chan_q  <= '0;
      smosi_q <= '0;
      dmosi_q <= '0;
      smiso_q <= '0;
      dmiso_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= s_gpio_shk_tri_o[CW-1:0];
      req_q   <= req_d;
      ack_q   <= ack_d;
      chan_q  <= chan_d;
      smosi_q <= smosi_d;
      dmosi_q <= dmosi_d;
      smiso_q <= smiso_d;
      dmiso_q <= dmiso_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHAN; c++) begin
      m_shk_ctrl_wvalid[c] = (state_q == VALID) &&
                             (chan_q == WD_CSEL'(c));
    end
  end

  assign m_shk_ctrl_smosi = smosi_q;
  assign m_shk_ctrl_dmosi = dmosi_q;

  always_comb begin
    s_gpio_shk_tri_i                = '0;
    s_gpio_shk_tri_i[0]             = ack_q;
    s_gpio_shk_tri_i[1 +: WD_SYNC]  = smiso_q;
    s_gpio_shk_tri_i[DB +: WD_DLAY] = dmiso_q;
    s_gpio_shk_tri_i[CB]            = (state_q == VALID);
`ifdef GPIO_SHK_TIMEOUT_EN
    s_gpio_shk_tri_i[CB+1]          = tflag_q;
`endif
  end

endmodule

// File: tb/tb_gpio_shk_mc.sv
// Bench for gpio_shk_mc: vector table, hand sequences, random traffic.
// Timeout checks compile in with GPIO_SHK_TIMEOUT_EN.
module tb_gpio_shk_mc;

  logic        clk;
  logic        rst;
  logic [63:0] tri_o;
  logic [63:0] tri_i;
  logic [3:0]  wvalid;
  logic [15:0] smosi;
  logic [14:0] dmosi;
  logic [3:0]  wready;
  logic [63:0] smiso;
  logic [59:0] dmiso;

  int total = 0;
  int bad   = 0;

  bit          tog;
  logic [15:0] last_rs;
  logic [14:0] last_rd;
  bit          last_tf;

  gpio_shk_mc #(
    .WD_GPIO(64),
    .WD_SYNC(16),
    .WD_DLAY(15),
    .WD_CSEL(2),
    .WD_TOUT(4)
  ) dut (
    .s_sys_base_clock (clk),
    .s_sys_base_reset (rst),
    .s_gpio_shk_tri_o (tri_o),
    .s_gpio_shk_tri_i (tri_i),
    .m_shk_ctrl_wvalid(wvalid),
    .m_shk_ctrl_smosi (smosi),
    .m_shk_ctrl_dmosi (dmosi),
    .m_shk_ctrl_wready(wready),
    .m_shk_ctrl_smiso (smiso),
    .m_shk_ctrl_dmiso (dmiso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] sm;
    logic [14:0] dm;
    logic [15:0] rs;
    logic [14:0] rd;
    int          d;
    bit          pre;
    logic [3:0]  nz;
    logic [3:0]  ewv;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  function automatic logic [63:0] mk_stat(
    input bit ack, input logic [15:0] s, input logic [14:0] d,
    input bit busy, input bit tf);
    logic [63:0] w;
    w        = '0;
    w[0]     = ack;
    w[16:1]  = s;
    w[31:17] = d;
    w[32]    = busy;
    w[33]    = tf;
    return w;
  endfunction

  task automatic set_cmd(input bit t, input logic [1:0] c,
                         input logic [15:0] s, input logic [14:0] d);
    tri_o        = {$urandom, $urandom};
    tri_o[0]     = t;
    tri_o[16:1]  = s;
    tri_o[31:17] = d;
    tri_o[33:32] = c;
  endtask

  task automatic set_resp(input logic [1:0] c, input logic [15:0] s,
                          input logic [14:0] d);
    smiso = {$urandom, $urandom};
    dmiso = 60'({$urandom, $urandom});
    smiso[c*16 +: 16] = s;
    dmiso[c*15 +: 15] = d;
  endtask

  task automatic run_txn(
    input logic [1:0] ch, input logic [15:0] sm, input logic [14:0] dm,
    input logic [15:0] rs, input logic [14:0] rd, input int d,
    input bit pre, input logic [3:0] nz, input int flips,
    input logic [3:0] ewv);
    bit cur;
    tog = !tog;
    set_cmd(tog, ch, sm, dm);
    set_resp(ch, rs, rd);
    wready = pre ? (4'b1 << ch) : 4'b0;
    @(negedge clk);
    chk("lat_wv", wvalid, 0);
    chk("lat_st", tri_i, mk_stat(!tog, last_rs, last_rd, 0, last_tf));
    @(negedge clk);
    chk("wv", wvalid, ewv);
    chk("smosi", smosi, sm);
    chk("dmosi", dmosi, dm);
    chk("busy_st", tri_i, mk_stat(!tog, last_rs, last_rd, 1, 0));
    if (!pre) begin
      for (int k = 0; k < d; k++) begin
        wready = nz & ~(4'b1 << ch);
        cur = tri_o[0];
        if (k < flips) cur = !cur;
        set_cmd(cur, 2'($urandom), 16'($urandom), 15'($urandom));
        @(negedge clk);
        chk("hold_wv", wvalid, ewv);
        chk("hold_smosi", smosi, sm);
        chk("hold_dmosi", dmosi, dm);
        chk("hold_st", tri_i, mk_stat(!tog, last_rs, last_rd, 1, 0));
      end
      wready = (4'b1 << ch) | nz;
    end
    @(negedge clk);
    chk("done_wv", wvalid, 0);
    chk("done_st", tri_i, mk_stat(tog, rs, rd, 0, 0));
    last_rs = rs;
    last_rd = rd;
    last_tf = 0;
    wready  = 4'b0;
  endtask

  initial begin
    logic [1:0]  ch2;
    logic [15:0] sm2;
    logic [15:0] rs2;
    logic [14:0] rd2;
    int          n;
    int          d;

    vecs[0] = '{2'd2, 16'h1234, 15'h0055, 16'hABCD, 15'h0077,
                2, 0, 4'b1011, 4'b0100};
    vecs[1] = '{2'd0, 16'hFFFF, 15'h7FFF, 16'h0000, 15'h0000,
                0, 0, 4'b0000, 4'b0001};
    vecs[2] = '{2'd3, 16'h0000, 15'h0000, 16'hFFFF, 15'h7FFF,
                1, 0, 4'b0111, 4'b1000};
    vecs[3] = '{2'd1, 16'hA5A5, 15'h2AAA, 16'h5A5A, 15'h5555,
                0, 1, 4'b0000, 4'b0010};
    vecs[4] = '{2'd2, 16'h0F0F, 15'h1111, 16'h1357, 15'h2468,
                4, 0, 4'b1011, 4'b0100};
    vecs[5] = '{2'd1, 16'h8001, 15'h4001, 16'h7FFE, 15'h3FFE,
                14, 0, 4'b1101, 4'b0010};

    clk = 0; rst = 1; tri_o = '0; wready = '0;
    smiso = '0; dmiso = '0;
    tog = 0; last_rs = '0; last_rd = '0; last_tf = 0;

    repeat (3) @(negedge clk);
    chk("rst_tri_i", tri_i, 0);
    chk("rst_wv", wvalid, 0);
    chk("rst_smosi", smosi, 0);
    chk("rst_dmosi", dmosi, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("idle_tri_i", tri_i, 0);
    chk("idle_wv", wvalid, 0);

    // reset in VALID aborts, then a high toggle at release restarts
    tog = 1;
    set_cmd(1, 2'd1, 16'h1111, 15'h0222);
    set_resp(2'd1, 16'hDEAD, 15'h0BEE);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wv", wvalid, 4'b0010);
    rst = 1;
    wready = 4'b0010;
    @(negedge clk);
    chk("rstv_wv", wvalid, 0);
    chk("rstv_st", tri_i, 0);
    wready = 4'b0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rel_lat_wv", wvalid, 0);
    @(negedge clk);
    chk("rel_wv", wvalid, 4'b0010);
    chk("rel_smosi", smosi, 16'h1111);
    wready = 4'b0010;
    @(negedge clk);
    chk("rel_st", tri_i, mk_stat(1, 16'hDEAD, 15'h0BEE, 0, 0));
    last_rs = 16'hDEAD; last_rd = 15'h0BEE;
    wready = 4'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].ch, vecs[i].sm, vecs[i].dm, vecs[i].rs,
              vecs[i].rd, vecs[i].d, vecs[i].pre, vecs[i].nz, 0,
              vecs[i].ewv);
    end

    // two toggles during VALID cancel out
    run_txn(2'd3, 16'h2222, 15'h0333, 16'h4444, 15'h0555,
            4, 0, 4'b0101, 2, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("even_idle_wv", wvalid, 0);
    end

    // one toggle during VALID issues after one idle cycle
    run_txn(2'd0, 16'h6666, 15'h0777, 16'h8888, 15'h0999,
            3, 0, 4'b1110, 1, 4'b0001);
    ch2 = tri_o[33:32];
    sm2 = tri_o[16:1];
    rs2 = 16'hC3C3;
    rd2 = 15'h1E1E;
    set_resp(ch2, rs2, rd2);
    @(negedge clk);
    chk("b2b_wv", wvalid, 4'b1 << ch2);
    chk("b2b_smosi", smosi, sm2);
    tog = tri_o[0];
    wready = 4'b1 << ch2;
    @(negedge clk);
    chk("b2b_st", tri_i, mk_stat(tog, rs2, rd2, 0, 0));
    last_rs = rs2; last_rd = rd2;
    wready = 4'b0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      ch2 = 2'($urandom);
      d = $urandom_range(0, 10);
      run_txn(ch2, 16'($urandom), 15'($urandom), 16'($urandom),
              15'($urandom), d, (d == 0) && ($urandom_range(0, 1) == 1),
              4'($urandom),
              ((d >= 2) && ($urandom_range(0, 1) == 1)) ? 2 : 0,
              4'b1 << ch2);
    end

`ifdef GPIO_SHK_TIMEOUT_EN
    tog = !tog;
    set_cmd(tog, 2'd3, 16'h0BAD, 15'h0123);
    set_resp(2'd3, 16'hFACE, 15'h0FED);
    wready = 4'b0111;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wvalid == 4'b1000) n++;
      else if (n > 0) break;
    end
    chk("tout_cycles", n, 15);
    chk("tout_st", tri_i, mk_stat(tog, 0, 0, 0, 1));
    last_rs = '0; last_rd = '0; last_tf = 1;
    wready = 4'b0;
    run_txn(2'd2, 16'h1357, 15'h0246, 16'h9999, 15'h0AAA,
            3, 0, 4'b0000, 0, 4'b0100);
`else
    tog = !tog;
    set_cmd(tog, 2'd3, 16'h0BAD, 15'h0123);
    set_resp(2'd3, 16'hFACE, 15'h0FED);
    wready = 4'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (wvalid == 4'b1000) n++;
    end
    chk("notout_cycles", n, 39);
    chk("notout_flag", tri_i[33], 0);
    wready = 4'b1000;
    @(negedge clk);
    chk("notout_st", tri_i, mk_stat(tog, 16'hFACE, 15'h0FED, 0, 0));
    wready = 4'b0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_shk_mc.md
GPIO_SHK_MC -- requirements
Module: gpio_shk_mc

Interface
- REQ-001 Parameter WD_GPIO, default 64, shall set the GPIO word width and shall be >= WD_SYNC+WD_DLAY+WD_CSEL+3.
- REQ-002 Parameter WD_SYNC, default 16, shall set the sync field width.
- REQ-003 Parameter WD_DLAY, default 15, shall set the delay field width.
- REQ-004 Parameter WD_CSEL, default 2, shall set the channel-select width; NUM_CHAN = 2**WD_CSEL.
- REQ-005 Parameter WD_TOUT, default 16, shall set the timeout counter width.
- REQ-006 s_sys_base_clock  in  1  sole clock; all logic on the rising edge.
- REQ-007 s_sys_base_reset  in  1  reset, synchronous, active-high.
- REQ-008 s_gpio_shk_tri_o  in  WD_GPIO  command word: [0] request toggle; [WD_SYNC:1] smosi; [WD_DLAY+WD_SYNC:WD_SYNC+1] dmosi; next WD_CSEL bits = channel; upper bits ignored.
- REQ-009 s_gpio_shk_tri_i  out  WD_GPIO  status word: [0] ack toggle; [WD_SYNC:1] smiso; [WD_DLAY+WD_SYNC:WD_SYNC+1] dmiso; [WD_DLAY+WD_SYNC+1] busy; [WD_DLAY+WD_SYNC+2] timeout flag; remaining bits 0.
- REQ-010 m_shk_ctrl_wvalid  out  NUM_CHAN  per-channel valid, one-hot or zero.
- REQ-011 m_shk_ctrl_smosi  out  WD_SYNC  sync payload, shared by all channels.
- REQ-012 m_shk_ctrl_dmosi  out  WD_DLAY  delay payload, shared by all channels.
- REQ-013 m_shk_ctrl_wready  in  NUM_CHAN  per-channel ready.
- REQ-014 m_shk_ctrl_smiso  in  NUM_CHAN*WD_SYNC  per-channel sync response; channel c at [c*WD_SYNC +: WD_SYNC].
- REQ-015 m_shk_ctrl_dmiso  in  NUM_CHAN*WD_DLAY  per-channel delay response; channel c at [c*WD_DLAY +: WD_DLAY].

Function
- REQ-016 The block shall implement FSM states IDLE, VALID.
- REQ-017 In IDLE, when tri_o[0] != req_last, the block shall latch smosi, dmosi and channel from tri_o, set req_last <= tri_o[0], clear the timeout flag, and enter VALID.
- REQ-018 Latency: the toggle change sampled at edge N shall produce wvalid[chan]=1 and busy=1 after edge N+1.
- REQ-019 In VALID, only wvalid[chan] shall be 1 and smosi/dmosi/channel shall stay stable; tri_o changes shall be ignored.
- REQ-020 A transfer occurs on an edge where wvalid[chan]=1 and wready[chan]=1; that edge shall capture smiso/dmiso slice chan into the status word, set ack toggle <= req_last, clear wvalid and busy, and return to IDLE.
- REQ-021 wready on non-selected channels shall be ignored; wready asserted before wvalid shall complete the transfer on the first VALID cycle.
- REQ-022 Status smiso/dmiso shall hold their last captured values until the next transfer or timeout.
- REQ-023 Toggle changes during VALID shall be evaluated only on return to IDLE against req_last; an even number of changes during VALID shall start no transaction.
- REQ-024 Back-to-back: a toggle change already pending at return to IDLE shall issue wvalid one cycle after IDLE is re-entered (one idle cycle minimum).

Reset
- REQ-025 On reset: state IDLE, req_last=0, ack toggle=0, busy=0, timeout flag=0, status smiso/dmiso=0, wvalid=0, smosi=0, dmosi=0, timeout counter=0.
- REQ-026 Reset asserted in VALID shall abort the transaction with no ack toggle change and no capture.
- REQ-027 tri_o[0]=1 at reset release shall start a transaction.

Configuration
- REQ-028 With GPIO_SHK_TIMEOUT_EN defined, a WD_TOUT-bit counter shall clear on entering VALID and increment each VALID cycle; reaching all-ones without a transfer shall clear wvalid, set ack toggle <= req_last, set timeout flag=1, zero status smiso/dmiso, and return to IDLE.
- REQ-029 Transfer and timeout on the same edge shall be treated as a transfer (flag stays 0).
- REQ-030 Without GPIO_SHK_TIMEOUT_EN, no counter shall exist, VALID shall wait indefinitely, and the timeout flag bit shall read 0.

Verification
- REQ-031 Reset, tri_o=0 -> all outputs 0, tri_i=0.
- REQ-032 tri_o: toggle 0->1, chan=2, smosi=0x1234, dmosi=0x0055; wready[2]=1 after 3 cycles, smiso[2]=0xABCD, dmiso[2]=0x0077 -> wvalid=4'b0100 for 3 cycles; tri_i ack=1, smiso=0xABCD, dmiso=0x0077, busy=0.
- REQ-033 wready=4'b1011 held while chan=2 is requested -> wvalid[2] stays high, no ack; then set wready[2]=1 -> completes next edge.
- REQ-034 Toggle 1->0->1 during VALID -> no second transaction; single toggle during VALID -> second wvalid one cycle after return to IDLE.
- REQ-035 With GPIO_SHK_TIMEOUT_EN, WD_TOUT=4, wready=0 -> wvalid low after 15 VALID cycles, timeout flag=1, ack toggled, status data 0.
- REQ-036 Reset pulse mid-VALID -> wvalid=0 next edge, ack unchanged at 0.
